burst_read_responder: RTL and testbench

BURST_READ_RESPONDER -- requirements
Module: burst_read_responder

---
 rtl/burst_read_responder.sv | 200 ++++++++++++++++++++
 tb/tb_burst_read_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_read_responder.sv
// rtl/burst_read_responder.sv - burst read responder over a byte-writable on-chip scratchpad
//
// Purpose: accepts one-cycle burst read requests addressed in half-words and
// streams the requested scratchpad words back one beat per cycle. The first
// beat appears two cycles after the request, and a single-cycle done pulse
// follows the last beat. A fill port writes the scratchpad in any state.
//
// Optional feature: define BURST_RESP_HALFWORD_EN to enable 16-bit beats
// (burst_32bit = 0). Without it, every burst uses 32-bit beats.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   burst_rd            one-cycle burst request strobe
//   burst_addr[24:0]    half-word start address
//   burst_len[10:0]     burst length in half-words
//   burst_32bit         1 = 32-bit beats, 0 = 16-bit beats (optional feature)
//   burst_data[31:0]    beat data, zero when not valid
//   burst_data_valid    beat qualifier
//   burst_data_done     one-cycle end-of-burst pulse
//   busy                high from the accepted request through the done cycle
//   mem_wr, mem_waddr[10:0], mem_wdata[31:0], mem_wstrb[3:0]   fill port
//   err_range, err_busy sticky error flags; err_clr clears them
module burst_read_responder #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        burst_rd,
   input  logic [24:0] burst_addr,
   input  logic [10:0] burst_len,
   input  logic        burst_32bit,
   output logic [31:0] burst_data,
   output logic        burst_data_valid,
   output logic        burst_data_done,
   input  logic        mem_wr,
   input  logic [10:0] mem_waddr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        busy,
   output logic        err_range,
   output logic        err_busy,
   input  logic        err_clr
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [25:0] DEPTH_W = 26'(DEPTH_WORDS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_LAST = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   // Beat address: word address for 32-bit bursts, half-word address for
   // 16-bit bursts. Kept wider than any request so the range check sees the
   // address before wrapping.
   logic [25:0] addr_q, addr_d;
   logic [10:0] remain_q, remain_d;
   logic        hw_q, hw_d;

   logic        req_hw;
   logic [25:0] req_addr;
   logic [10:0] req_len;

   logic        issue;
   logic [25:0] word_addr;
   logic [AW-1:0] mem_idx;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] rd_word_q;
   logic        valid_q;
   logic        hsel_q;
   logic        hwbeat_q;
   logic        err_range_q;
   logic        err_busy_q;

   logic        unused_bits;
   assign unused_bits = ^{burst_addr[0], burst_len[0], burst_32bit, mem_waddr};

   // Request decode: 32-bit bursts drop the half-word bit of address and length.
   always_comb begin
`ifdef BURST_RESP_HALFWORD_EN
      req_hw = ~burst_32bit;
`else
      req_hw = 1'b0;
`endif
      if (req_hw) begin
         req_addr = {1'b0, burst_addr};
         req_len  = burst_len;
      end else begin
         req_addr = {2'b00, burst_addr[24:1]};
         req_len  = {1'b0, burst_len[10:1]};
      end
   end

   assign word_addr = hw_q ? {1'b0, addr_q[25:1]} : addr_q;
   assign mem_idx   = word_addr[AW-1:0];
   assign issue     = (state_q == S_READ) && (remain_q != '0);

   // READ issues one scratchpad read per cycle; LAST is the cycle the final
   // beat is on the output; DONE carries the done pulse.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      hw_d     = hw_q;
      case (state_q)
         S_IDLE: begin
            if (burst_rd) begin
               state_d  = S_READ;
               addr_d   = req_addr;
               remain_d = req_len;
               hw_d     = req_hw;
            end
         end
         S_READ: begin
            if (remain_q == '0) begin
               state_d = S_DONE;
            end else begin
               addr_d   = addr_q + 26'd1;
               remain_d = remain_q - 11'd1;
               if (remain_q == 11'd1) begin
                  state_d = S_LAST;
               end
            end
         end
         S_LAST:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remain_q    <= '0;
         hw_q        <= 1'b0;
         rd_word_q   <= '0;
         valid_q     <= 1'b0;
         hsel_q      <= 1'b0;
         hwbeat_q    <= 1'b0;
         err_range_q <= 1'b0;
         err_busy_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         hw_q     <= hw_d;
         valid_q  <= issue;
         // Read samples the array before this edge's write lands, so a
         // same-cycle write to the same word returns the old contents.
         if (issue) begin
            rd_word_q <= mem[mem_idx];
            hsel_q    <= addr_q[0];
            hwbeat_q  <= hw_q;
         end
         // Set has priority over clear.
         if (issue && (word_addr >= DEPTH_W)) begin
            err_range_q <= 1'b1;
         end else if (err_clr) begin
            err_range_q <= 1'b0;
         end
         if (burst_rd && (state_q != S_IDLE)) begin
            err_busy_q <= 1'b1;
         end else if (err_clr) begin
            err_busy_q <= 1'b0;
         end
      end
   end

   // Scratchpad storage is deliberately outside reset so contents survive it.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) begin
               mem[mem_waddr[AW-1:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      burst_data = 32'h0;
      if (valid_q) begin
         if (hwbeat_q) begin
            burst_data = {16'h0, hsel_q ? rd_word_q[31:16] : rd_word_q[15:0]};
         end else begin
            burst_data = rd_word_q;
         end
      end
   end

   assign burst_data_valid = valid_q;
   assign burst_data_done  = (state_q == S_DONE);
   assign busy             = (state_q != S_IDLE);
   assign err_range        = err_range_q;
   assign err_busy         = err_busy_q;

endmodule

// File: tb/tb_burst_read_responder.sv
// tb/tb_burst_read_responder.sv - directed self-checking bench for burst_read_responder
module tb_burst_read_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        burst_rd;
   logic [24:0] burst_addr;
   logic [10:0] burst_len;
   logic        burst_32bit;
   logic [31:0] burst_data;
   logic        burst_data_valid;
   logic        burst_data_done;
   logic        mem_wr;
   logic [10:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        busy;
   logic        err_range;
   logic        err_busy;
   logic        err_clr;

   int n_checks = 0;
   int n_fail   = 0;

   burst_read_responder #(.DEPTH_WORDS(1024)) dut (
      .clk              (clk),
      .reset            (reset),
      .burst_rd         (burst_rd),
      .burst_addr       (burst_addr),
      .burst_len        (burst_len),
      .burst_32bit      (burst_32bit),
      .burst_data       (burst_data),
      .burst_data_valid (burst_data_valid),
      .burst_data_done  (burst_data_done),
      .mem_wr           (mem_wr),
      .mem_waddr        (mem_waddr),
      .mem_wdata        (mem_wdata),
      .mem_wstrb        (mem_wstrb),
      .busy             (busy),
      .err_range        (err_range),
      .err_busy         (err_busy),
      .err_clr          (err_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
      mem_wr = 1'b1; mem_waddr = a; mem_wdata = d; mem_wstrb = s;
      tick();
      mem_wr = 1'b0;
   endtask

   // Issues a request in the current cycle (cycle 0) and returns in cycle 1.
   task automatic start_burst(input logic [24:0] a, input logic [10:0] l, input logic b32);
      burst_addr = a; burst_len = l; burst_32bit = b32; burst_rd = 1'b1;
      tick();
      burst_rd = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      n_checks += 6;
      if (burst_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h want=0", burst_data); end
      if (burst_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", burst_data_valid); end
      if (burst_data_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", burst_data_done); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (err_range !== 1'b0) begin n_fail++; $display("FAIL reset_err_range got=%b want=0", err_range); end
      if (err_busy !== 1'b0) begin n_fail++; $display("FAIL reset_err_busy got=%b want=0", err_busy); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_burst();
      logic ev;
      logic [31:0] ed;
      for (int i = 0; i < 8; i++) write_word(11'(i), 32'h1000 + 32'(i), 4'hF);
      write_word(11'd1022, 32'hCAFE03FE, 4'hF);
      write_word(11'd1023, 32'hCAFE03FF, 4'hF);
      tick();
      start_burst(25'h4, 11'd8, 1'b1);
      for (int cyc = 1; cyc <= 7; cyc++) begin
         ev = (cyc >= 2 && cyc <= 5);
         ed = ev ? 32'h1000 + 32'(cyc) : 32'h0;
         n_checks += 4;
         if (burst_data_valid !== ev) begin n_fail++; $display("FAIL basic_valid c%0d got=%b want=%b", cyc, burst_data_valid, ev); end
         if (burst_data !== ed) begin n_fail++; $display("FAIL basic_data c%0d got=%h want=%h", cyc, burst_data, ed); end
         if (burst_data_done !== (cyc == 6)) begin n_fail++; $display("FAIL basic_done c%0d got=%b", cyc, burst_data_done); end
         if (busy !== (cyc <= 6)) begin n_fail++; $display("FAIL basic_busy c%0d got=%b", cyc, busy); end
         tick();
      end
      n_checks++;
      if (err_range !== 1'b0) begin n_fail++; $display("FAIL basic_err_range got=%b want=0", err_range); end
   endtask

   task automatic test_zero_len();
      start_burst(25'h6, 11'd0, 1'b1);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         n_checks += 3;
         if (burst_data_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid c%0d got=%b want=0", cyc, burst_data_valid); end
         if (burst_data_done !== (cyc == 2)) begin n_fail++; $display("FAIL zero_done c%0d got=%b", cyc, burst_data_done); end
         if (busy !== (cyc <= 2)) begin n_fail++; $display("FAIL zero_busy c%0d got=%b", cyc, busy); end
         tick();
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_beats [4];
      logic ev;
      logic [31:0] ed;
      exp_beats[0] = 32'hCAFE03FE; exp_beats[1] = 32'hCAFE03FF;
      exp_beats[2] = 32'h00001000; exp_beats[3] = 32'h00001001;
      start_burst(25'd2044, 11'd8, 1'b1);
      for (int cyc = 1; cyc <= 7; cyc++) begin
         ev = (cyc >= 2 && cyc <= 5);
         ed = ev ? exp_beats[cyc-2] : 32'h0;
         n_checks += 3;
         if (burst_data_valid !== ev) begin n_fail++; $display("FAIL wrap_valid c%0d got=%b want=%b", cyc, burst_data_valid, ev); end
         if (burst_data !== ed) begin n_fail++; $display("FAIL wrap_data c%0d got=%h want=%h", cyc, burst_data, ed); end
         if (burst_data_done !== (cyc == 6)) begin n_fail++; $display("FAIL wrap_done c%0d got=%b", cyc, burst_data_done); end
         if (cyc == 3) begin
            n_checks++;
            if (err_range !== 1'b0) begin n_fail++; $display("FAIL wrap_err_early got=%b want=0", err_range); end
         end
         tick();
      end
      n_checks++;
      if (err_range !== 1'b1) begin n_fail++; $display("FAIL wrap_err_range got=%b want=1", err_range); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if (err_range !== 1'b0) begin n_fail++; $display("FAIL wrap_err_clr got=%b want=0", err_range); end
   endtask

   task automatic test_write_strobe();
      write_word(11'd5, 32'hFFFFFFFF, 4'b0010);
      write_word(11'h406, 32'h66666666, 4'hF);
      tick();
      start_burst(25'd10, 11'd4, 1'b1);
      tick();
      n_checks += 2;
      if (burst_data !== 32'h0000FF05) begin n_fail++; $display("FAIL strobe_data got=%h want=0000ff05", burst_data); end
      if (burst_data_valid !== 1'b1) begin n_fail++; $display("FAIL strobe_valid got=%b want=1", burst_data_valid); end
      tick();
      n_checks++;
      if (burst_data !== 32'h66666666) begin n_fail++; $display("FAIL alias_data got=%h want=66666666", burst_data); end
      tick();
      n_checks++;
      if (burst_data_done !== 1'b1) begin n_fail++; $display("FAIL strobe_done got=%b want=1", burst_data_done); end
      tick(); tick();
   endtask

   task automatic test_back_to_back();
      logic ev;
      logic [31:0] ed;
      start_burst(25'd0, 11'd8, 1'b1);
      for (int cyc = 1; cyc <= 9; cyc++) begin
         if (cyc == 3) begin
            // Collides with the burst in flight; err_clr in the same cycle must lose.
            burst_addr = 25'd40; burst_len = 11'd2; burst_rd = 1'b1; err_clr = 1'b1;
         end
         ev = (cyc >= 2 && cyc <= 5);
         ed = ev ? 32'h1000 + 32'(cyc - 2) : 32'h0;
         n_checks += 3;
         if (burst_data_valid !== ev) begin n_fail++; $display("FAIL b2b_valid c%0d got=%b want=%b", cyc, burst_data_valid, ev); end
         if (burst_data !== ed) begin n_fail++; $display("FAIL b2b_data c%0d got=%h want=%h", cyc, burst_data, ed); end
         if (burst_data_done !== (cyc == 6)) begin n_fail++; $display("FAIL b2b_done c%0d got=%b", cyc, burst_data_done); end
         tick();
         burst_rd = 1'b0; err_clr = 1'b0;
      end
      n_checks += 2;
      if (err_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_err_busy got=%b want=1", err_busy); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after got=%b want=0", busy); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if (err_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_err_clr got=%b want=0", err_busy); end
   endtask

   task automatic test_read_before_write();
      start_burst(25'd14, 11'd2, 1'b1);
      mem_wr = 1'b1; mem_waddr = 11'd7; mem_wdata = 32'hDEAD0007; mem_wstrb = 4'hF;
      tick();
      mem_wr = 1'b0;
      n_checks++;
      if (burst_data !== 32'h00001007) begin n_fail++; $display("FAIL rbw_old got=%h want=00001007", burst_data); end
      tick(); tick(); tick();
      start_burst(25'd14, 11'd2, 1'b1);
      tick();
      n_checks++;
      if (burst_data !== 32'hDEAD0007) begin n_fail++; $display("FAIL rbw_new got=%h want=dead0007", burst_data); end
      tick(); tick(); tick();
   endtask

   task automatic test_reset_midburst();
      start_burst(25'd0, 11'd12, 1'b1);
      tick();
      tick();
      n_checks++;
      if (burst_data !== 32'h00001001) begin n_fail++; $display("FAIL rst_pre_data got=%h want=00001001", burst_data); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int cyc = 4; cyc <= 9; cyc++) begin
         n_checks += 3;
         if (burst_data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid c%0d got=%b want=0", cyc, burst_data_valid); end
         if (burst_data_done !== 1'b0) begin n_fail++; $display("FAIL rst_done c%0d got=%b want=0", cyc, burst_data_done); end
         if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy c%0d got=%b want=0", cyc, busy); end
         tick();
      end
      start_burst(25'd0, 11'd4, 1'b1);
      tick();
      n_checks++;
      if (burst_data !== 32'h00001000) begin n_fail++; $display("FAIL rst_keep0 got=%h want=00001000", burst_data); end
      tick();
      n_checks++;
      if (burst_data !== 32'h00001001) begin n_fail++; $display("FAIL rst_keep1 got=%h want=00001001", burst_data); end
      tick(); tick(); tick();
   endtask

   task automatic test_beat_mode();
      write_word(11'd0, 32'hAAAA5555, 4'hF);
      tick();
      start_burst(25'd0, 11'd2, 1'b0);
      tick();
`ifdef BURST_RESP_HALFWORD_EN
      n_checks += 2;
      if (burst_data !== 32'h00005555) begin n_fail++; $display("FAIL hw_beat0 got=%h want=00005555", burst_data); end
      if (burst_data_valid !== 1'b1) begin n_fail++; $display("FAIL hw_valid0 got=%b want=1", burst_data_valid); end
      tick();
      n_checks++;
      if (burst_data !== 32'h0000AAAA) begin n_fail++; $display("FAIL hw_beat1 got=%h want=0000aaaa", burst_data); end
      tick();
      n_checks += 2;
      if (burst_data_done !== 1'b1) begin n_fail++; $display("FAIL hw_done got=%b want=1", burst_data_done); end
      if (burst_data_valid !== 1'b0) begin n_fail++; $display("FAIL hw_valid_end got=%b want=0", burst_data_valid); end
`else
      n_checks += 2;
      if (burst_data !== 32'hAAAA5555) begin n_fail++; $display("FAIL w32_beat got=%h want=aaaa5555", burst_data); end
      if (burst_data_valid !== 1'b1) begin n_fail++; $display("FAIL w32_valid got=%b want=1", burst_data_valid); end
      tick();
      n_checks += 2;
      if (burst_data_done !== 1'b1) begin n_fail++; $display("FAIL w32_done got=%b want=1", burst_data_done); end
      if (burst_data_valid !== 1'b0) begin n_fail++; $display("FAIL w32_valid_end got=%b want=0", burst_data_valid); end
`endif
      tick(); tick();
   endtask

   initial begin
      reset = 1'b1; burst_rd = 1'b0; burst_addr = '0; burst_len = '0; burst_32bit = 1'b1;
      mem_wr = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_wstrb = '0; err_clr = 1'b0;
      test_reset();
      test_basic_burst();
      test_zero_len();
      test_wrap();
      test_write_strobe();
      test_back_to_back();
      test_read_before_write();
      test_reset_midburst();
      test_beat_mode();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
